// File: rtl/tspi_pkg.sv
// Shared definitions for the SPI transmit feeder: default widths and FSM state encoding.
package tspi_pkg;

    localparam int unsigned SPI0_0  = 8;
    localparam int unsigned FIFO_AW = 4;
    localparam int unsigned LEN_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/tspi_tx_feeder_if.sv
// Host-side and transmit-stage signals of the feeder; slave modport faces the feeder.
// abort is present only when TSPI_FEEDER_ABORT_EN is defined.
interface tspi_tx_feeder_if #(
    parameter int unsigned SPI0_0  = tspi_pkg::SPI0_0,
    parameter int unsigned FIFO_AW = tspi_pkg::FIFO_AW,
    parameter int unsigned LEN_W   = tspi_pkg::LEN_W
) ();

    logic              wr_en;
    logic [SPI0_0-1:0] wr_data;
    logic              wr_full;
    logic [FIFO_AW:0]  fifo_level;
    logic              start;
    logic [LEN_W-1:0]  frame_len;
    logic              busy;
    logic              frame_done;
    logic              overflow;
    logic              txd_en;
    logic              txd_cmpt;
    logic              tx_dreq;
    logic              tx_valid;
    logic [SPI0_0-1:0] tx_data;
`ifdef TSPI_FEEDER_ABORT_EN
    logic              abort;
`endif

    modport slave (
`ifdef TSPI_FEEDER_ABORT_EN
        input  abort,
`endif
        input  wr_en, wr_data, start, frame_len, txd_cmpt, tx_dreq,
        output wr_full, fifo_level, busy, frame_done, overflow, txd_en, tx_valid, tx_data
    );

    modport master (
`ifdef TSPI_FEEDER_ABORT_EN
        output abort,
`endif
        output wr_en, wr_data, start, frame_len, txd_cmpt, tx_dreq,
        input  wr_full, fifo_level, busy, frame_done, overflow, txd_en, tx_valid, tx_data
    );

endinterface

// File: rtl/tspi_tx_fifo.sv
// Synchronous FIFO with registered level/full/empty and a flush that discards all content.
// Read data is the head entry, valid whenever empty is low.
module tspi_tx_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_c, pop_c;

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        pop_c    = rd_en && !empty_q && !flush;
        push_c   = wr_en && (!full_q || pop_c) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
        end
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = count_q;

endmodule

// File: rtl/tspi_tx_feeder.sv
// Frame sequencer feeding bytes from a host FIFO to the SPI transmit stage.
// Define TSPI_FEEDER_ABORT_EN to add the abort input (flush + early frame end).
module tspi_tx_feeder #(
    parameter int unsigned SPI0_0  = tspi_pkg::SPI0_0,
    parameter int unsigned FIFO_AW = tspi_pkg::FIFO_AW,
    parameter int unsigned LEN_W   = tspi_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    tspi_tx_feeder_if.slave   bus
);

    import tspi_pkg::*;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              tx_valid_q, tx_valid_d;
    logic [SPI0_0-1:0] tx_data_q, tx_data_d;

    logic              abort_c, start_acc_c, pop_c;
    logic              fifo_full, fifo_empty;
    logic [SPI0_0-1:0] fifo_rd_data;
    logic [FIFO_AW:0]  fifo_level;

`ifdef TSPI_FEEDER_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    assign start_acc_c = bus.start && (state_q == ST_IDLE) && !abort_c;
    // A request, live or remembered, is served only once a byte is actually available.
    assign pop_c = (state_q == ST_RUN) && (bus.tx_dreq || pending_q) && !fifo_empty && !abort_c;

    tspi_tx_fifo #(.DW(SPI0_0), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort_c),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_acc_c && (bus.frame_len != '0)) state_d = ST_RUN;
            ST_RUN:   if (pop_c && (remaining_q == LEN_W'(1))) state_d = ST_DRAIN;
            ST_DRAIN: if (bus.txd_cmpt) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_c) state_d = ST_IDLE;
    end

    always_comb begin
        remaining_d  = remaining_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        tx_valid_d   = pop_c;
        tx_data_d    = pop_c ? fifo_rd_data : tx_data_q;

        if (start_acc_c) begin
            overflow_d = 1'b0;
            if (bus.frame_len == '0) frame_done_d = 1'b1;
            else                     remaining_d  = bus.frame_len;
        end
        if (state_q == ST_RUN) begin
            if (pop_c) begin
                remaining_d = remaining_q - LEN_W'(1);
                pending_d   = 1'b0;
            end else if (bus.tx_dreq && fifo_empty) begin
                pending_d = 1'b1;
            end
        end
        if ((state_q == ST_DRAIN) && bus.txd_cmpt) frame_done_d = 1'b1;
        if (bus.wr_en && fifo_full && !pop_c && !abort_c) overflow_d = 1'b1;
        if (abort_c && (state_q != ST_IDLE)) begin
            frame_done_d = 1'b1;
            pending_d    = 1'b0;
            remaining_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q  <= '0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            remaining_q  <= remaining_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // txd_en tracks the frame exactly, so it shares the busy register.
    assign bus.busy       = busy_q;
    assign bus.txd_en     = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.wr_full    = fifo_full;
    assign bus.fifo_level = fifo_level;

endmodule

// File: tb/tb_tspi_tx_feeder.sv
// Directed self-checking bench for tspi_tx_feeder; covers abort when TSPI_FEEDER_ABORT_EN is defined.
module tb_tspi_tx_feeder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    tspi_tx_feeder_if #(.SPI0_0(8), .FIFO_AW(4), .LEN_W(16)) bus ();

    tspi_tx_feeder #(.SPI0_0(8), .FIFO_AW(4), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.txd_en, bus.tx_valid, bus.frame_done, bus.overflow, bus.wr_full} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.busy, bus.txd_en, bus.tx_valid, bus.frame_done, bus.overflow, bus.wr_full});
        end
        checks++;
        if (bus.fifo_level !== 5'd0 || bus.tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_level_data: level=%0d data=%h expected 0/00", bus.fifo_level, bus.tx_data);
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        push(8'h11); push(8'h22); push(8'h33);
        checks++;
        if (bus.fifo_level !== 5'd3) begin
            failures++;
            $display("FAIL basic_level: got %0d expected 3", bus.fifo_level);
        end
        bus.start = 1'b1; bus.frame_len = 16'd3;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.txd_en} !== 2'b11) begin
            failures++;
            $display("FAIL basic_start: busy/txd_en=%b expected 11", {bus.busy, bus.txd_en});
        end
        for (int i = 0; i < 3; i++) begin
            bus.tx_dreq = 1'b1;
            tick();
            bus.tx_dreq = 1'b0;
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i]) begin
                failures++;
                $display("FAIL basic_byte%0d: valid=%b data=%h expected 1/%h", i, bus.tx_valid, bus.tx_data, exp[i]);
            end
            tick();
            checks++;
            if (bus.tx_valid !== 1'b0 || bus.tx_data !== exp[i]) begin
                failures++;
                $display("FAIL basic_strobe%0d: valid=%b data=%h expected 0/%h", i, bus.tx_valid, bus.tx_data, exp[i]);
            end
        end
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        checks++;
        if ({bus.busy, bus.txd_en, bus.tx_valid} !== 3'b110) begin
            failures++;
            $display("FAIL basic_drain: busy/txd_en/valid=%b expected 110", {bus.busy, bus.txd_en, bus.tx_valid});
        end
        bus.txd_cmpt = 1'b1;
        tick();
        bus.txd_cmpt = 1'b0;
        checks++;
        if ({bus.busy, bus.txd_en, bus.frame_done} !== 3'b001) begin
            failures++;
            $display("FAIL basic_end: busy/txd_en/done=%b expected 001", {bus.busy, bus.txd_en, bus.frame_done});
        end
        tick();
        checks++;
        if (bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b expected 0", bus.frame_done);
        end
    endtask

    task automatic test_pending();
        bus.start = 1'b1; bus.frame_len = 16'd2;
        tick();
        bus.start = 1'b0;
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_empty: valid=%b expected 0", bus.tx_valid);
        end
        tick();
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        push(8'hA5);
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.fifo_level !== 5'd1) begin
            failures++;
            $display("FAIL pend_push: valid=%b level=%0d expected 0/1", bus.tx_valid, bus.fifo_level);
        end
        tick();
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5 || bus.fifo_level !== 5'd0) begin
            failures++;
            $display("FAIL pend_serve: valid=%b data=%h level=%0d expected 1/a5/0", bus.tx_valid, bus.tx_data, bus.fifo_level);
        end
        push(8'h5A);
        tick();
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.fifo_level !== 5'd1) begin
            failures++;
            $display("FAIL pend_cleared: valid=%b level=%0d expected 0/1", bus.tx_valid, bus.fifo_level);
        end
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5A) begin
            failures++;
            $display("FAIL pend_second: valid=%b data=%h expected 1/5a", bus.tx_valid, bus.tx_data);
        end
        bus.txd_cmpt = 1'b1;
        tick();
        bus.txd_cmpt = 1'b0;
        checks++;
        if ({bus.busy, bus.frame_done} !== 2'b01) begin
            failures++;
            $display("FAIL pend_end: busy/done=%b expected 01", {bus.busy, bus.frame_done});
        end
    endtask

    task automatic test_overflow_full();
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        checks++;
        if (bus.wr_full !== 1'b1 || bus.fifo_level !== 5'd16 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_fill: full=%b level=%0d ovf=%b expected 1/16/0", bus.wr_full, bus.fifo_level, bus.overflow);
        end
        push(8'h50);
        checks++;
        if (bus.wr_full !== 1'b1 || bus.fifo_level !== 5'd16 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: full=%b level=%0d ovf=%b expected 1/16/1", bus.wr_full, bus.fifo_level, bus.overflow);
        end
        bus.start = 1'b1; bus.frame_len = 16'd2;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b busy=%b expected 0/1", bus.overflow, bus.busy);
        end
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE; bus.tx_dreq = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.tx_dreq = 1'b0;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h40 || bus.fifo_level !== 5'd16 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop: valid=%b data=%h level=%0d ovf=%b expected 1/40/16/0",
                     bus.tx_valid, bus.tx_data, bus.fifo_level, bus.overflow);
        end
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        checks++;
        if (bus.tx_data !== 8'h41 || bus.fifo_level !== 5'd15) begin
            failures++;
            $display("FAIL full_second: data=%h level=%0d expected 41/15", bus.tx_data, bus.fifo_level);
        end
        bus.txd_cmpt = 1'b1;
        tick();
        bus.txd_cmpt = 1'b0;
        checks++;
        if (bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL full_end: done=%b expected 1", bus.frame_done);
        end
    endtask

    task automatic test_busy_start();
        logic [7:0] e;
        bus.start = 1'b1; bus.frame_len = 16'd15;
        tick();
        bus.start = 1'b0;
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        checks++;
        if (bus.tx_data !== 8'h42) begin
            failures++;
            $display("FAIL busy_first: data=%h expected 42", bus.tx_data);
        end
        bus.start = 1'b1; bus.frame_len = 16'd100;
        tick();
        bus.start = 1'b0;
        bus.tx_dreq = 1'b1;
        for (int i = 0; i < 14; i++) begin
            e = (i < 13) ? (8'h43 + 8'(i)) : 8'hEE;
            tick();
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== e) begin
                failures++;
                $display("FAIL busy_byte%0d: valid=%b data=%h expected 1/%h", i, bus.tx_valid, bus.tx_data, e);
            end
        end
        bus.tx_dreq = 1'b0;
        bus.txd_cmpt = 1'b1;
        tick();
        bus.txd_cmpt = 1'b0;
        checks++;
        if ({bus.busy, bus.frame_done, bus.fifo_level} !== {2'b01, 5'd0}) begin
            failures++;
            $display("FAIL busy_end: busy=%b done=%b level=%0d expected 0/1/0", bus.busy, bus.frame_done, bus.fifo_level);
        end
    endtask

    task automatic test_zero_len();
        bus.start = 1'b1; bus.frame_len = 16'd0;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.frame_done, bus.txd_en, bus.busy} !== 3'b100) begin
            failures++;
            $display("FAIL zero_start: done/txd_en/busy=%b expected 100", {bus.frame_done, bus.txd_en, bus.busy});
        end
        tick();
        checks++;
        if ({bus.frame_done, bus.txd_en} !== 2'b00) begin
            failures++;
            $display("FAIL zero_after: done/txd_en=%b expected 00", {bus.frame_done, bus.txd_en});
        end
    endtask

    task automatic test_rst_mid();
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        bus.start = 1'b1; bus.frame_len = 16'd4;
        tick();
        bus.start = 1'b0;
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        push(8'h65);
        checks++;
        if (bus.tx_data !== 8'h61 || bus.fifo_level !== 5'd4 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: data=%h level=%0d busy=%b expected 61/4/1", bus.tx_data, bus.fifo_level, bus.busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.txd_en, bus.tx_valid, bus.frame_done, bus.overflow, bus.wr_full} !== 6'b0
            || bus.tx_data !== 8'h00 || bus.fifo_level !== 5'd0) begin
            failures++;
            $display("FAIL rst_mid: flags=%b data=%h level=%0d expected 000000/00/0",
                     {bus.busy, bus.txd_en, bus.tx_valid, bus.frame_done, bus.overflow, bus.wr_full},
                     bus.tx_data, bus.fifo_level);
        end
    endtask

`ifdef TSPI_FEEDER_ABORT_EN
    task automatic test_abort();
        push(8'h71);
        bus.start = 1'b1; bus.frame_len = 16'd1;
        tick();
        bus.start = 1'b0;
        bus.tx_dreq = 1'b1;
        tick();
        bus.tx_dreq = 1'b0;
        push(8'h72); push(8'h73);
        checks++;
        if (bus.busy !== 1'b1 || bus.fifo_level !== 5'd2) begin
            failures++;
            $display("FAIL abort_pre: busy=%b level=%0d expected 1/2", bus.busy, bus.fifo_level);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.frame_done, bus.txd_en, bus.busy, bus.tx_valid} !== 4'b1000 || bus.fifo_level !== 5'd0) begin
            failures++;
            $display("FAIL abort_drain: done/txd_en/busy/valid=%b level=%0d expected 1000/0",
                     {bus.frame_done, bus.txd_en, bus.busy, bus.tx_valid}, bus.fifo_level);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.start = 1'b0; bus.frame_len = '0;
        bus.txd_cmpt = 1'b0; bus.tx_dreq = 1'b0;
`ifdef TSPI_FEEDER_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_basic_frame();
        test_pending();
        test_overflow_full();
        test_busy_start();
        test_zero_len();
        test_rst_mid();
`ifdef TSPI_FEEDER_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
